arcade_video_timing: RTL

ARCADE_VIDEO_TIMING -- requirements
Module: arcade_video_timing

---
 rtl/arcade_video_timing.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/arcade_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : arcade_video_timing
// Purpose  : Pixel-enable divider plus H/V raster counters, blanking and syncs.
//            Define ARCADE_TIMING_POS_ADJ_EN to enable frame-latched h_adj/v_adj.
// Revision : 1.0 - initial release
// ============================================================================
module arcade_video_timing #(
  parameter int CE_DIV   = 4,
  parameter int WIDTH    = 320,
  parameter int H_TOTAL  = 384,
  parameter int HS_START = 336,
  parameter int HS_LEN   = 32,
  parameter int HEIGHT   = 240,
  parameter int V_TOTAL  = 264,
  parameter int VS_START = 244,
  parameter int VS_LEN   = 3
) (
  input  logic       clk_video,
  input  logic       reset,
  input  logic [3:0] h_adj,
  input  logic [3:0] v_adj,
  output logic       ce_pix,
  output logic [9:0] hcnt,
  output logic [8:0] vcnt,
  output logic       HBlank,
  output logic       VBlank,
  output logic       HSync,
  output logic       VSync,
  output logic       frame_start
);

  localparam logic [3:0]         c_DIV_LAST = 4'(CE_DIV - 1);
  localparam logic [9:0]         c_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [8:0]         c_V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [9:0]         c_WIDTH    = 10'(WIDTH);
  localparam logic [8:0]         c_HEIGHT   = 9'(HEIGHT);
  localparam logic signed [10:0] c_HS_START = 11'(HS_START);
  localparam logic signed [10:0] c_HS_SPAN  = 11'(HS_LEN - 1);
  localparam logic signed [10:0] c_VS_START = 11'(VS_START);
  localparam logic signed [10:0] c_VS_SPAN  = 11'(VS_LEN - 1);

  generate
    if (CE_DIV < 2 || CE_DIV > 16) begin : g_bad_ce_div
      $error("arcade_video_timing: CE_DIV must be in 2..16");
    end
    if (WIDTH >= H_TOTAL || H_TOTAL > 1024) begin : g_bad_h_geom
      $error("arcade_video_timing: need WIDTH < H_TOTAL <= 1024");
    end
    if (HEIGHT >= V_TOTAL || V_TOTAL > 512) begin : g_bad_v_geom
      $error("arcade_video_timing: need HEIGHT < V_TOTAL <= 512");
    end
  endgenerate

  logic [3:0]         r_div;
  logic [9:0]         r_h;
  logic [8:0]         r_v;
  logic [9:0]         w_h_nxt;
  logic [8:0]         w_v_nxt;
  logic               w_div_last;
  logic [3:0]         w_hadj_l;
  logic [3:0]         w_vadj_l;
  logic signed [10:0] w_hs_lo;
  logic signed [10:0] w_hs_hi;
  logic signed [10:0] w_vs_lo;
  logic signed [10:0] w_vs_hi;
  logic signed [10:0] w_h_s;
  logic signed [10:0] w_v_s;
  logic               w_hs_on;
  logic               w_vs_on;
  logic               w_vs_edge;

`ifdef ARCADE_TIMING_POS_ADJ_EN
  logic [3:0] r_hadj_l;
  logic [3:0] r_vadj_l;

  // Offsets only move on the last pixel of a frame so a frame never tears.
  always_ff @(posedge clk_video) begin
    if (reset) begin
      r_hadj_l <= '0;
      r_vadj_l <= '0;
    end else if (ce_pix && (hcnt == c_H_LAST) && (vcnt == c_V_LAST)) begin
      r_hadj_l <= h_adj;
      r_vadj_l <= v_adj;
    end
  end

  assign w_hadj_l = r_hadj_l;
  assign w_vadj_l = r_vadj_l;
`else
  logic w_unused_adj;

  assign w_unused_adj = ^{h_adj, v_adj};
  assign w_hadj_l     = '0;
  assign w_vadj_l     = '0;
`endif

  assign w_div_last = (r_div == c_DIV_LAST);

  assign w_hs_lo = c_HS_START + $signed({{7{w_hadj_l[3]}}, w_hadj_l});
  assign w_hs_hi = w_hs_lo + c_HS_SPAN;
  assign w_vs_lo = c_VS_START + $signed({{7{w_vadj_l[3]}}, w_vadj_l});
  assign w_vs_hi = w_vs_lo + c_VS_SPAN;

  assign w_h_s     = {1'b0, r_h};
  assign w_v_s     = {2'b00, r_v};
  assign w_hs_on   = (w_h_s >= w_hs_lo) && (w_h_s <= w_hs_hi);
  assign w_vs_on   = (w_v_s >= w_vs_lo) && (w_v_s <= w_vs_hi);
  assign w_vs_edge = (w_h_s == w_hs_lo);

  always_comb begin
    w_h_nxt = r_h + 10'd1;
    w_v_nxt = r_v;
    if (r_h == c_H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v == c_V_LAST) ? '0 : r_v + 9'd1;
    end
  end

  // r_h/r_v hold the pixel to present at the next ce_pix, so every output
  // is derived from the same position in the same edge (zero skew).
  always_ff @(posedge clk_video) begin
    if (reset) begin
      r_div       <= '0;
      r_h         <= '0;
      r_v         <= '0;
      ce_pix      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      HBlank      <= 1'b0;
      VBlank      <= 1'b0;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_div       <= w_div_last ? '0 : r_div + 4'd1;
      ce_pix      <= w_div_last;
      frame_start <= w_div_last && (r_h == '0) && (r_v == '0);
      if (w_div_last) begin
        r_h    <= w_h_nxt;
        r_v    <= w_v_nxt;
        hcnt   <= r_h;
        vcnt   <= r_v;
        HBlank <= (r_h >= c_WIDTH);
        VBlank <= (r_v >= c_HEIGHT);
        HSync  <= w_hs_on;
        if (w_vs_edge) begin
          VSync <= w_vs_on;
        end
      end
    end
  end

endmodule
`default_nettype wire
